// File: rtl/cmos_rgb565_capture.sv
`default_nettype none
// ============================================================================
// Module   : cmos_rgb565_capture
// Purpose  : Packs the 8-bit DVP byte stream of a CMOS sensor into 16-bit
//            RGB565 pixels, with frame/line markers and pixel coordinates.
//            A configurable number of frames is discarded after reset.
// Revision : 1.0 - initial release
// ============================================================================
module cmos_rgb565_capture #(
    parameter int FRAME_SKIP      = 10,
    parameter bit HIGH_BYTE_FIRST = 1'b1,
    parameter int CNT_W           = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmos_vsync,
    input  logic             cmos_href,
    input  logic [7:0]       cmos_data,
    output logic [15:0]      pixel_data,
    output logic             pixel_valid,
    output logic             pixel_sof,
    output logic             line_end,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             capture_active,
    output logic             line_err
);

    // Frame counter only needs to reach FRAME_SKIP; keep at least one bit.
    localparam int                C_FC_W = (FRAME_SKIP < 1) ? 1 : $clog2(FRAME_SKIP + 1);
    localparam logic [C_FC_W-1:0] C_SKIP = C_FC_W'(FRAME_SKIP);

    logic              r_vs_d1;
    logic              r_vs_d2;
    logic              r_href_d1;
    logic              r_href_d2;
    logic [7:0]        r_data_d1;
    logic [C_FC_W-1:0] r_frame_cnt;
    logic              r_phase;
    logic [7:0]        r_hold;
    logic              r_sof_armed;
    logic [CNT_W-1:0]  r_x_next;
    logic [CNT_W-1:0]  r_y_cur;
    logic              r_line_has_pix;

    logic              w_vs_rise;
    logic              w_href_fall;
    logic              w_emit;
    logic              w_odd_end;
    logic              w_line_done;
    logic [15:0]       w_pair;

    assign w_vs_rise   = r_vs_d1 & ~r_vs_d2;
    assign w_href_fall = ~r_href_d1 & r_href_d2;
    // Second byte of a pair is in d1: a pixel completes this cycle.
    assign w_emit      = capture_active & r_href_d1 & r_phase;
    // Line closed with a dangling first byte.
    assign w_odd_end   = capture_active & w_href_fall & r_phase;
    assign w_line_done = capture_active & w_href_fall & r_line_has_pix;
    assign w_pair      = HIGH_BYTE_FIRST ? {r_hold, r_data_d1} : {r_data_d1, r_hold};

    // Input registers (d1) and a second stage (d2) for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vs_d1   <= 1'b0;
            r_vs_d2   <= 1'b0;
            r_href_d1 <= 1'b0;
            r_href_d2 <= 1'b0;
            r_data_d1 <= 8'h00;
        end else begin
            r_vs_d1   <= cmos_vsync;
            r_vs_d2   <= r_vs_d1;
            r_href_d1 <= cmos_href;
            r_href_d2 <= r_href_d1;
            r_data_d1 <= cmos_data;
        end
    end

    // Frame gating: skip FRAME_SKIP frames, then start on a vsync rise so the
    // first captured frame is complete; stays active until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt    <= '0;
            capture_active <= 1'b0;
        end else if (w_vs_rise) begin
            if (r_frame_cnt == C_SKIP) begin
                capture_active <= 1'b1;
            end else begin
                r_frame_cnt <= r_frame_cnt + C_FC_W'(1);
            end
        end
    end

    // Byte packing, pixel strobe and start-of-frame marker.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase     <= 1'b0;
            r_hold      <= 8'h00;
            r_sof_armed <= 1'b0;
            pixel_data  <= 16'h0000;
            pixel_valid <= 1'b0;
            pixel_sof   <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            pixel_sof   <= 1'b0;
            if (r_href_d1 && capture_active) begin
                r_phase <= ~r_phase;
            end else begin
                r_phase <= 1'b0;
            end
            if (r_href_d1 && capture_active && !r_phase) begin
                r_hold <= r_data_d1;
            end
            if (w_emit) begin
                pixel_data  <= w_pair;
                pixel_valid <= 1'b1;
                // A pixel finishing on the vsync rise belongs to the old frame.
                pixel_sof   <= r_sof_armed & ~w_vs_rise;
            end
            if (w_vs_rise) begin
                r_sof_armed <= 1'b1;
            end else if (w_emit) begin
                r_sof_armed <= 1'b0;
            end
        end
    end

    // Coordinates, end-of-line pulse and odd-byte-count flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x_next       <= '0;
            r_y_cur        <= '0;
            r_line_has_pix <= 1'b0;
            pixel_x        <= '0;
            pixel_y        <= '0;
            line_end       <= 1'b0;
            line_err       <= 1'b0;
        end else begin
            line_end <= w_line_done;
            if (w_emit) begin
                r_x_next <= r_x_next + CNT_W'(1);
            end else if (!r_href_d1) begin
                r_x_next <= '0;
            end
            if (w_emit) begin
                r_line_has_pix <= 1'b1;
            end else if (!r_href_d1) begin
                r_line_has_pix <= 1'b0;
            end
            if (w_vs_rise) begin
                r_y_cur <= '0;
            end else if (w_line_done) begin
                r_y_cur <= r_y_cur + CNT_W'(1);
            end
            if (w_emit) begin
                pixel_x <= r_x_next;
                pixel_y <= r_y_cur;
            end else if (w_vs_rise) begin
                pixel_y <= '0;
            end
            if (w_vs_rise) begin
                line_err <= 1'b0;
            end else if (w_odd_end) begin
                line_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmos_rgb565_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmos_rgb565_capture
// Purpose  : Self-checking bench for cmos_rgb565_capture. Two instances
//            (high-byte-first and low-byte-first) share one DVP stream; a
//            frame/line level model predicts every pixel, marker and flag.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmos_rgb565_capture;

    localparam int FRAME_SKIP = 2;
    localparam int CNT_W      = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             vsync = 1'b0;
    logic             href = 1'b0;
    logic [7:0]       data = 8'h00;

    logic [15:0]      pd_h, pd_l;
    logic             pv_h, pv_l, sof_h, sof_l, le_h, le_l, cap_h, cap_l, err_h, err_l;
    logic [CNT_W-1:0] px_h, py_h, px_l, py_l;

    cmos_rgb565_capture #(.FRAME_SKIP(FRAME_SKIP), .HIGH_BYTE_FIRST(1'b1), .CNT_W(CNT_W)) dut_h (
        .clk(clk), .rst_n(rst_n), .cmos_vsync(vsync), .cmos_href(href), .cmos_data(data),
        .pixel_data(pd_h), .pixel_valid(pv_h), .pixel_sof(sof_h), .line_end(le_h),
        .pixel_x(px_h), .pixel_y(py_h), .capture_active(cap_h), .line_err(err_h)
    );

    cmos_rgb565_capture #(.FRAME_SKIP(FRAME_SKIP), .HIGH_BYTE_FIRST(1'b0), .CNT_W(CNT_W)) dut_l (
        .clk(clk), .rst_n(rst_n), .cmos_vsync(vsync), .cmos_href(href), .cmos_data(data),
        .pixel_data(pd_l), .pixel_valid(pv_l), .pixel_sof(sof_l), .line_end(le_l),
        .pixel_x(px_l), .pixel_y(py_l), .capture_active(cap_l), .line_err(err_l)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] d;
        int          x;
        int          y;
        bit          sof;
        int          cyc;
    } pix_t;

    pix_t       q[$];
    int         vs_count   = 0;
    bit         captured   = 1'b0;
    bit         first_pix  = 1'b0;
    int         y_lines    = 0;
    bit         err_exp    = 1'b0;
    int         le_exp     = 0;
    int         le_cnt     = 0;
    logic [7:0] lb [1280];

    task automatic fill_random();
        for (int i = 0; i < 1280; i++) lb[i] = 8'($urandom);
    endtask

    task automatic model_reset();
        vs_count  = 0;
        captured  = 1'b0;
        first_pix = 1'b0;
        y_lines   = 0;
        err_exp   = 1'b0;
    endtask

    task automatic check_zero();
        check("rst_valid", pv_h, 0);
        check("rst_data", pd_h, 0);
        check("rst_data_l", pd_l, 0);
        check("rst_sof", sof_h, 0);
        check("rst_line_end", le_h, 0);
        check("rst_x", px_h, 0);
        check("rst_y", py_h, 0);
        check("rst_capture", cap_h, 0);
        check("rst_err", err_h, 0);
    endtask

    // Vsync pulse; optional href/data activity while vsync is high.
    task automatic drive_vsync(input int high_cycles, input bit toggle);
        for (int i = 0; i < high_cycles; i++) begin
            @(posedge clk); #1;
            vsync = 1'b1;
            if (toggle) begin
                href = 1'($urandom_range(0, 1));
                data = 8'($urandom);
            end
        end
        @(posedge clk); #1;
        vsync = 1'b0;
        href  = 1'b0;
        vs_count++;
        if (!captured && vs_count == FRAME_SKIP + 1) captured = 1'b1;
        if (captured) begin
            first_pix = 1'b1;
            y_lines   = 0;
        end
        err_exp = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    // One line of n bytes from lb[]; rst_at >= 0 pulses rst_n with that byte.
    task automatic drive_line(input int n, input int rst_at);
        int x;
        pix_t e;
        x = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (rst_at >= 0 && i == rst_at + 1) check_zero();
            href  = 1'b1;
            data  = lb[i];
            rst_n = (rst_at == i) ? 1'b0 : 1'b1;
            if ((i % 2 == 1) && captured && (rst_at < 0 || i <= rst_at - 2)) begin
                e.d   = {lb[i-1], lb[i]};
                e.x   = x % (1 << CNT_W);
                e.y   = y_lines;
                e.sof = first_pix;
                e.cyc = cyc + 2;
                q.push_back(e);
                first_pix = 1'b0;
                x++;
            end
        end
        @(posedge clk); #1;
        href  = 1'b0;
        rst_n = 1'b1;
        data  = 8'($urandom);
        if (rst_at >= 0) begin
            model_reset();
        end else if (captured) begin
            if (n / 2 > 0) begin
                le_exp++;
                y_lines++;
            end
            if (n % 2 == 1) err_exp = 1'b1;
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic frame_check();
        @(negedge clk);
        check("pending_pixels", q.size(), 0);
        check("line_end_count", le_cnt, le_exp);
        check("line_err", err_h, err_exp);
        check("line_err_pair", err_l, err_h);
        check("capture_active", cap_h, captured);
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        pix_t e;
        if (pv_h || pv_l) begin
            check("valid_pair", pv_l, pv_h);
            if (q.size() == 0) begin
                check("extra_pixel", pv_h | pv_l, 0);
            end else begin
                e = q.pop_front();
                check("pix_data_h", pd_h, e.d);
                check("pix_data_l", pd_l, {e.d[7:0], e.d[15:8]});
                check("pix_x", px_h, e.x);
                check("pix_y", py_h, e.y);
                check("pix_sof", sof_h, e.sof);
                check("pix_latency", cyc, e.cyc);
            end
        end
        if (sof_h && !pv_h) check("sof_without_valid", sof_h, 0);
        if (le_h) le_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero();
        rst_n = 1'b1;

        // Skipped frames, with href activity during vsync and an odd line.
        for (int f = 0; f < FRAME_SKIP; f++) begin
            drive_vsync(6, 1'b1);
            fill_random();
            drive_line(8, -1);
            drive_line(5, -1);
            frame_check();
            check("precap_x", px_h, 0);
            check("precap_y", py_h, 0);
        end

        // First captured frame: 4x2 pixels.
        drive_vsync(6, 1'b0);
        for (int l = 0; l < 2; l++) begin
            fill_random();
            drive_line(8, -1);
        end
        frame_check();

        // Byte order.
        drive_vsync(4, 1'b0);
        lb[0] = 8'hF8;
        lb[1] = 8'h1F;
        drive_line(2, -1);
        @(negedge clk);
        check("order_high_first", pd_h, 16'hF81F);
        check("order_low_first", pd_l, 16'h1FF8);
        frame_check();

        // 640 x 3 lines.
        drive_vsync(4, 1'b0);
        for (int l = 0; l < 3; l++) begin
            fill_random();
            drive_line(1280, -1);
            @(negedge clk);
            check("line_last_x", px_h, 639);
            check("line_y", py_h, l);
        end
        frame_check();
        drive_vsync(4, 1'b0);
        @(negedge clk);
        check("y_after_vsync", py_h, 0);

        // Odd byte count: flag sticks until the next vsync.
        fill_random();
        drive_line(5, -1);
        frame_check();
        fill_random();
        drive_line(4, -1);
        frame_check();
        drive_vsync(4, 1'b0);
        frame_check();

        // Random frames.
        for (int f = 0; f < 3; f++) begin
            drive_vsync(int'($urandom_range(3, 8)), 1'b0);
            for (int l = 0; l < int'($urandom_range(1, 4)); l++) begin
                fill_random();
                drive_line(int'($urandom_range(1, 24)), -1);
            end
            frame_check();
        end

        // Reset in the middle of a captured line.
        drive_vsync(4, 1'b0);
        fill_random();
        drive_line(40, 20);
        frame_check();
        for (int f = 0; f < FRAME_SKIP; f++) begin
            drive_vsync(6, 1'b1);
            fill_random();
            drive_line(8, -1);
            frame_check();
        end
        drive_vsync(5, 1'b0);
        for (int l = 0; l < 2; l++) begin
            fill_random();
            drive_line(10, -1);
        end
        frame_check();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
